// File: rtl/mau_pkg.sv
// mau_pkg: shared FSM state, access-size encodings and datapath width for mem_access_unit.
package mau_pkg;
  localparam int MAU_XLEN = 64;
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
endpackage

// File: rtl/mau_lane_merge.sv
// mau_lane_merge: store byte-lane merge into a read doubleword and load extract with sign/zero extension.
module mau_lane_merge
  import mau_pkg::*;
#(parameter int XLEN = MAU_XLEN) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] merged,
  output logic [XLEN-1:0] ext
);
  logic [XLEN-1:0] mask;
  logic sign;
  always_comb begin
    // 1 << 64 wraps to 0, so the double case yields an all-ones mask
    mask = (XLEN'(1) << (7'd8 << size)) - XLEN'(1);
    sign = size == SZ_B ? rdata[7] : size == SZ_H ? rdata[15] : rdata[31];
    merged = (rdata & ~mask) | (wdata & mask);
    ext = (is_unsigned || size == SZ_D || !sign) ? (rdata & mask) : (rdata | ~mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with read-modify-write for sub-doubleword stores.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned accesses with rsp_err instead of executing them.
module mem_access_unit
  import mau_pkg::*;
#(parameter int XLEN = MAU_XLEN) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [XLEN-1:0] Mem_Addr,
  output logic [XLEN-1:0] Write_Data,
  input  logic [XLEN-1:0] Read_Data
);
  state_t state;
  logic write_q, uns_q, misaligned;
  logic [1:0] size_q;
  logic [XLEN-1:0] wdata_q, merged, ext;
`ifdef MAU_MISALIGN_TRAP_EN
  assign misaligned = |({1'b0, req_addr[2:0]} & ((4'd1 << req_size) - 4'd1));
`else
  assign misaligned = 1'b0;
`endif
  assign req_ready = state == IDLE && !reset;
  assign rsp_valid = state == RSP;
  assign MemRead = state == RD;
  assign MemWrite = state == WR;
  mau_lane_merge #(.XLEN(XLEN)) u_lane (
    .rdata(Read_Data),
    .wdata(wdata_q),
    .size(size_q),
    .is_unsigned(uns_q),
    .merged(merged),
    .ext(ext)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      wdata_q <= '0;
      Mem_Addr <= '0;
      Write_Data <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q <= req_write;
          size_q <= req_size;
          uns_q <= req_unsigned;
          wdata_q <= req_wdata;
          rsp_err <= misaligned;
          rsp_rdata <= '0;
          if (misaligned) state <= RSP;
          else if (req_write && req_size == SZ_D) begin
            state <= WR;
            Mem_Addr <= req_addr;
            Write_Data <= req_wdata;
          end else begin
            state <= RD;
            Mem_Addr <= req_addr;
          end
        end
        RD: begin
          state <= write_q ? WR : RSP;
          if (write_q) Write_Data <= merged;
          else rsp_rdata <= ext;
        end
        WR: state <= RSP;
        RSP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath and address width; only 64 is supported.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline presents an access.
REQ-005 req_ready  out  1  unit accepts an access; high only in IDLE.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  0=byte, 1=half, 2=word, 3=double.
REQ-008 req_unsigned  in  1  zero-extend load result (lbu/lhu/lwu).
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-aligned.
REQ-011 rsp_valid  out  1  result/completion available.
REQ-012 rsp_ready  in  1  pipeline consumes response.
REQ-013 rsp_rdata  out  64  extended load data; 0 for stores.
REQ-014 rsp_err  out  1  access rejected (see Configuration).
REQ-015 MemRead, MemWrite  out  1 each  data-memory strobes.
REQ-016 Mem_Addr, Write_Data  out  64 each  data-memory address and write data.
REQ-017 Read_Data  in  64  data memory combinational read of 8 bytes at Mem_Addr, little-endian.

Function
REQ-018 FSM states IDLE, RD, WR, RSP, all registered.
REQ-019 Handshake: request accepted on an edge with req_valid & req_ready; all req_* fields captured at that edge.
REQ-020 IDLE -> RD for any load or for a store with size<3; IDLE -> WR for size=3 store.
REQ-021 RD: MemRead=1, Mem_Addr=captured addr; Read_Data captured at end of cycle; next state RSP (load) or WR (store).
REQ-022 WR: MemWrite=1 for exactly one cycle; Write_Data = captured Read_Data with low 2^size bytes replaced by req_wdata's low bytes (size=3: req_wdata unchanged); next state RSP.
REQ-023 Load result: low 2^size bytes of captured Read_Data, sign-extended from the top byte unless req_unsigned; size=3 ignores req_unsigned.
REQ-024 RSP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready; on rsp_ready -> IDLE.
REQ-025 Latency accept-to-rsp_valid: load 2 cycles, sub-double store 3, double store 2.
REQ-026 Outside RD/WR, MemRead=MemWrite=0; Mem_Addr and Write_Data hold last driven value.
REQ-027 Addresses pass through unmodified; wrap-around is the memory's responsibility.
REQ-028 req_valid while not in IDLE is ignored and not captured.

Reset
REQ-029 reset asserted forces IDLE immediately, independent of clk.
REQ-030 While reset asserted: rsp_valid=0, rsp_rdata=0, rsp_err=0, MemRead=0, MemWrite=0, Mem_Addr=0, Write_Data=0, req_ready=0.
REQ-031 Reset during WR drops MemWrite combinationally; the in-flight access is discarded with no response.
REQ-032 First accept possible on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro MAU_MISALIGN_TRAP_EN: when defined, an access with req_addr mod 2^size != 0 performs no memory cycle, goes IDLE -> RSP, rsp_err=1, rsp_rdata=0.
REQ-034 When undefined, misaligned accesses execute normally and rsp_err is tied 0.

Structure
REQ-035 Package mau_pkg holds the FSM state enum, req_size encodings, and XLEN constant.
REQ-036 Sub-module mau_lane_merge: combinational store-byte merge and load extract/extend, instantiated once.

Verification
REQ-037 Memory preloaded byte[i]=i+1; ld addr 0 -> rsp_rdata=0x0807060504030201 two cycles after accept, MemWrite never high.
REQ-038 sb addr 3 wdata 0x80; then lb addr 3 -> 0xFFFFFFFFFFFFFF80; lbu addr 3 -> 0x0000000000000080.
REQ-039 sh addr 10 wdata 0xBEEF (RD then single WR cycle); ld addr 8 -> 0x100F0E0DBEEF0A09.
REQ-040 sd addr 16 wdata 0x1122334455667788 -> MemRead never high, one MemWrite cycle; rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0.
REQ-041 Reset asserted mid-WR of sw addr 24 -> MemWrite falls same cycle, no rsp_valid; ld addr 24 -> 0x201F1E1D1C1B1A19.
REQ-042 With MAU_MISALIGN_TRAP_EN, lw addr 2 -> rsp_err=1, rsp_rdata=0, one cycle after accept, no MemRead; without it -> 0x06050403.
